// File: rtl/regfile_sb.sv
// General-purpose register file with a per-register busy scoreboard, same-cycle
// write bypass and a post-reset clear sequencer that zeroes one entry per cycle.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD*ADDR_W-1:0]    raddr,
  output logic [NRD*DATA_W-1:0]    rdata,
  output logic [NRD-1:0]           rbusy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     init_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
  logic                init_done_nxt;
  logic [DATA_W-1:0]   rf [DEPTH];
  logic [DEPTH-1:0]    busy;
  logic                ready;
  logic                wr_en;

  assign ready = (state == READY);
  assign wr_en = ready && we && (waddr != '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      init_done <= init_done_nxt;
    end
  end

  // Clear sequencer: walk every entry once, then open the file
  always_comb begin
    state_nxt     = state;
    clr_cnt_nxt   = clr_cnt;
    init_done_nxt = init_done;
    case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt     = READY;
          init_done_nxt = 1'b1;
        end
      end
      READY: begin
        state_nxt = READY;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // Storage: no reset, contents defined once the clear sequence has run
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        rf[clr_cnt] <= '0;
      end else if (wr_en) begin
        rf[waddr] <= wdata;
      end
    end
  end

  // Scoreboard: a new producer (issue) outranks a retiring one (write)
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else if (ready) begin
      if (we && (waddr != '0)) busy[waddr] <= 1'b0;
      if (issue_valid && (issue_addr != '0)) busy[issue_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit;
    logic              live;

    assign a    = raddr[i*ADDR_W +: ADDR_W];
    assign live = ready && (a != '0);
    assign hit  = (BYPASS != 0) && we && (waddr == a);

    assign rdata[i*DATA_W +: DATA_W] = !live ? '0 : (hit ? wdata : rf[a]);
    assign rbusy[i]                  = live && busy[a] && !hit;
  end

endmodule
